// File: rtl/td4_program_sequencer.sv
// rtl/td4_program_sequencer.sv - TD4 program store, host loader and execute-strobe sequencer
// Define SEQ_BREAKPOINT_EN to enable the RUN-mode PC breakpoint (BRK state).
module td4_program_sequencer #(
    parameter int unsigned RUN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_i,
    input  logic [7:0] load_data_i,
    input  logic       load_valid_i,
    output logic       load_ready_o,
    input  logic       step_req_i,
    input  logic       bp_en_i,
    input  logic [3:0] bp_addr_i,
    input  logic [3:0] pc_i,
    output logic [3:0] opcode_o,
    output logic [3:0] immediate_o,
    output logic       exec_mode_o,
    output logic [3:0] load_addr_o,
    output logic       prog_full_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_BRK  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

    state_t     state_q, state_d, mode_state;
    logic [7:0] mem_q [16];
    logic [3:0] load_addr_q, load_addr_d;
    logic       prog_full_q, prog_full_d;
    logic       exec_q, exec_d;
    logic [7:0] div_q, div_d;
    logic       step_prev_q;
    logic       load_fire, run_expire, step_fire, bp_hit;

    assign load_ready_o = (state_q == S_LOAD) && !prog_full_q;
    assign load_fire    = load_ready_o && load_valid_i;
    assign step_fire    = (state_q == S_STEP) && step_req_i && !step_prev_q;

    assign opcode_o    = mem_q[pc_i][7:4];
    assign immediate_o = mem_q[pc_i][3:0];
    assign exec_mode_o = exec_q;
    assign load_addr_o = load_addr_q;
    assign prog_full_o = prog_full_q;
    assign state_o     = state_q;

`ifdef SEQ_BREAKPOINT_EN
    assign bp_hit = run_expire && bp_en_i && (pc_i == bp_addr_i);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en_i, bp_addr_i};
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        mode_state = S_IDLE;
        case (mode_i)
            2'b00:   mode_state = S_IDLE;
            2'b01:   mode_state = S_LOAD;
            2'b10:   mode_state = S_RUN;
            default: mode_state = S_STEP;
        endcase
    end

    // Divider only advances on edges where RUN is already the current state,
    // so the count is zero on the entry edge and the first expiry lands RUN_DIV cycles later.
    always_comb begin
        div_d      = 8'd0;
        run_expire = 1'b0;
        if (state_q == S_RUN) begin
            div_d      = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
            run_expire = (div_d == DIV_LAST);
        end
    end

    always_comb begin
        state_d = mode_state;
        if (bp_hit) begin
            state_d = S_BRK;
        end else if (state_q == S_BRK && mode_i == 2'b10) begin
            state_d = S_BRK;
        end
        exec_d = (run_expire && !bp_hit) || step_fire;
    end

    always_comb begin
        load_addr_d = load_addr_q;
        prog_full_d = prog_full_q;
        if (state_q != S_LOAD && state_d == S_LOAD) begin
            load_addr_d = 4'd0;
            prog_full_d = 1'b0;
        end else if (load_fire) begin
            load_addr_d = load_addr_q + 4'd1;
            if (load_addr_q == 4'd15) begin
                prog_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            load_addr_q <= 4'd0;
            prog_full_q <= 1'b0;
            exec_q      <= 1'b0;
            div_q       <= 8'd0;
            step_prev_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            prog_full_q <= prog_full_d;
            exec_q      <= exec_d;
            div_q       <= div_d;
            step_prev_q <= step_req_i;
            if (load_fire) begin
                mem_q[load_addr_q] <= load_data_i;
            end
        end
    end
endmodule

// File: tb/tb_td4_program_sequencer.sv
// tb/tb_td4_program_sequencer.sv - self-checking bench for td4_program_sequencer
module tb_td4_program_sequencer;
    localparam int RUN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_i;
    logic [7:0] load_data_i;
    logic       load_valid_i;
    logic       load_ready_o;
    logic       step_req_i;
    logic       bp_en_i;
    logic [3:0] bp_addr_i;
    logic [3:0] pc_i;
    logic [3:0] opcode_o;
    logic [3:0] immediate_o;
    logic       exec_mode_o;
    logic [3:0] load_addr_o;
    logic       prog_full_o;
    logic [2:0] state_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic       valid;
        logic [7:0] data;
        logic       step;
        logic [3:0] pc;
        logic [2:0] e_state;
        logic       e_exec;
        logic       e_ready;
        logic       e_full;
        logic [3:0] e_addr;
        logic [7:0] e_word;
    } vec_t;

    vec_t       tbl [19];
    logic [7:0] words [16];
    int         nstrobe;
    int         brk_seen;
    bit         reached;
    int         spc [$];

    // Reference model: program as a list of accepted words, RUN as a count of edges spent in RUN.
    int         m_state;
    logic [7:0] m_mem [16];
    int         m_n;
    int         m_run;
    bit         m_prev;
    bit         m_exec;

    always #5 clk = ~clk;

    td4_program_sequencer #(.RUN_DIV(RUN_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .load_data_i  (load_data_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .step_req_i   (step_req_i),
        .bp_en_i      (bp_en_i),
        .bp_addr_i    (bp_addr_i),
        .pc_i         (pc_i),
        .opcode_o     (opcode_o),
        .immediate_o  (immediate_o),
        .exec_mode_o  (exec_mode_o),
        .load_addr_o  (load_addr_o),
        .prog_full_o  (prog_full_o),
        .state_o      (state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge();
        bit expire;
        bit hit;
        bit fire;
        int nxt;
        if (!rst_n) begin
            m_state = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_n = 0;
            m_run = 0;
            m_prev = 1'b0;
            m_exec = 1'b0;
            return;
        end
        expire = 1'b0;
        hit = 1'b0;
        if (m_state == 2) begin
            m_run++;
            expire = ((m_run % RUN_DIV) == RUN_DIV - 1);
        end else begin
            m_run = 0;
        end
`ifdef SEQ_BREAKPOINT_EN
        hit = expire && bp_en_i && (pc_i == bp_addr_i);
`endif
        fire = (m_state == 3) && step_req_i && !m_prev;
        m_prev = step_req_i;
        if (m_state == 1 && load_valid_i && m_n < 16) begin
            m_mem[m_n] = load_data_i;
            m_n++;
        end
        if (hit) nxt = 4;
        else if (m_state == 4 && mode_i == 2'b10) nxt = 4;
        else nxt = int'(mode_i);
        if (nxt == 1 && m_state != 1) m_n = 0;
        m_exec = (expire && !hit) || fire;
        m_state = nxt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mode_i = 2'b00; load_data_i = 8'h00; load_valid_i = 1'b0;
        step_req_i = 1'b0; bp_en_i = 1'b0; bp_addr_i = 4'd0; pc_i = 4'd0;

        //          rst   mode   vld   data    stp   pc      st    ex    rdy   full  addr   word
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'd5, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'd9, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 4'd0, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[3]  = '{1'b1, 2'd1, 1'b1, 8'hC3, 1'b0, 4'd0, 3'd1, 1'b0, 1'b1, 1'b0, 4'd1, 8'hC3};
        tbl[4]  = '{1'b1, 2'd1, 1'b1, 8'hA2, 1'b0, 4'd1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd2, 8'hA2};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 8'hFF, 1'b0, 4'd1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd2, 8'hA2};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 8'hC3};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 4'd1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hA2};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 4'd0, 3'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[13] = '{1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[14] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[15] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[16] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[17] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 4'd0, 3'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'hC3};
        tbl[18] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 4'd2, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};

        for (int i = 0; i < 16; i++) begin
            if (i == 0) words[i] = 8'hC3;
            else if (i == 1) words[i] = 8'hA2;
            else words[i] = 8'(i * 37 + 11);
        end

        for (int r = 0; r < 19; r++) begin
            rst_n = tbl[r].rst_n; mode_i = tbl[r].mode; load_valid_i = tbl[r].valid;
            load_data_i = tbl[r].data; step_req_i = tbl[r].step; pc_i = tbl[r].pc;
            tick();
            chk($sformatf("tbl%0d state", r), 32'(state_o), 32'(tbl[r].e_state));
            chk($sformatf("tbl%0d exec", r), 32'(exec_mode_o), 32'(tbl[r].e_exec));
            chk($sformatf("tbl%0d ready", r), 32'(load_ready_o), 32'(tbl[r].e_ready));
            chk($sformatf("tbl%0d full", r), 32'(prog_full_o), 32'(tbl[r].e_full));
            chk($sformatf("tbl%0d addr", r), 32'(load_addr_o), 32'(tbl[r].e_addr));
            chk($sformatf("tbl%0d word", r), 32'({opcode_o, immediate_o}), 32'(tbl[r].e_word));
        end
        step_req_i = 1'b0;

        // Full 16-word load, then a rejected 17th word
        rst_n = 1'b0; mode_i = 2'b00; tick(); tick();
        rst_n = 1'b1; mode_i = 2'b01; tick();
        for (int i = 0; i < 16; i++) begin
            load_valid_i = 1'b1; load_data_i = words[i];
            tick();
            chk($sformatf("load%0d addr", i), 32'(load_addr_o), 32'((i + 1) % 16));
            chk($sformatf("load%0d full", i), 32'(prog_full_o), 32'(i == 15));
            chk($sformatf("load%0d ready", i), 32'(load_ready_o), 32'(i != 15));
        end
        load_data_i = 8'hEE; tick();
        chk("load17 addr", 32'(load_addr_o), 32'd0);
        chk("load17 full", 32'(prog_full_o), 32'd1);
        chk("load17 ready", 32'(load_ready_o), 32'd0);
        load_valid_i = 1'b0;
        for (int p = 0; p < 16; p++) begin
            pc_i = 4'(p); #1;
            chk($sformatf("readback pc%0d", p), 32'({opcode_o, immediate_o}), 32'(words[p]));
        end

        // RUN for 20 cycles: strobes in cycles 4,8,12,16,20
        pc_i = 4'd0; mode_i = 2'b10;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("run cyc%0d exec", c), 32'(exec_mode_o), 32'((c % RUN_DIV) == 0));
            chk($sformatf("run cyc%0d state", c), 32'(state_o), 32'd2);
        end
        mode_i = 2'b00; tick();
        chk("run exit exec", 32'(exec_mode_o), 32'd0);
        chk("run exit state", 32'(state_o), 32'd0);

        // Leaving RUN on the expiry edge still issues that strobe
        mode_i = 2'b10;
        for (int c = 1; c <= 3; c++) tick();
        mode_i = 2'b00; tick();
        chk("late strobe exec", 32'(exec_mode_o), 32'd1);
        chk("late strobe state", 32'(state_o), 32'd0);
        tick();
        chk("late strobe width", 32'(exec_mode_o), 32'd0);

        // Reset landing on the divider-expiry edge
        mode_i = 2'b10;
        for (int c = 1; c <= 3; c++) tick();
        rst_n = 1'b0; tick();
        chk("rst midrun exec", 32'(exec_mode_o), 32'd0);
        chk("rst midrun state", 32'(state_o), 32'd0);
        for (int p = 0; p < 16; p++) begin
            pc_i = 4'(p); #1;
            chk($sformatf("rst clear pc%0d", p), 32'({opcode_o, immediate_o}), 32'd0);
        end
        rst_n = 1'b1; mode_i = 2'b00; pc_i = 4'd0; tick();

        // STEP: held request gives one strobe, a later pulse gives another
        mode_i = 2'b11; tick();
        chk("step enter state", 32'(state_o), 32'd3);
        nstrobe = 0;
        for (int t = 0; t < 10; t++) begin
            step_req_i = (t < 5 || t == 7);
            tick();
            if (t == 0) chk("step first strobe", 32'(exec_mode_o), 32'd1);
            nstrobe += int'(exec_mode_o);
        end
        chk("step count", 32'(nstrobe), 32'd2);
        step_req_i = 1'b0; mode_i = 2'b00; tick();
        nstrobe = 0;
        step_req_i = 1'b1; tick(); nstrobe += int'(exec_mode_o);
        mode_i = 2'b11;    tick(); nstrobe += int'(exec_mode_o);
        tick();                    nstrobe += int'(exec_mode_o);
        chk("step idle edge discarded", 32'(nstrobe), 32'd0);
        step_req_i = 1'b0;

        // Breakpoint at PC 3, CPU advancing pc_i on each strobe
        rst_n = 1'b0; mode_i = 2'b00; tick();
        rst_n = 1'b1; pc_i = 4'd0; bp_en_i = 1'b1; bp_addr_i = 4'd3; mode_i = 2'b10;
`ifdef SEQ_BREAKPOINT_EN
        reached = 1'b0;
        spc.delete();
        for (int t = 0; t < 40 && !reached; t++) begin
            tick();
            if (exec_mode_o) begin
                spc.push_back(int'(pc_i));
                pc_i = pc_i + 4'd1;
            end
            if (state_o == 3'd4) reached = 1'b1;
        end
        chk("bp reached", 32'(reached), 32'd1);
        chk("bp strobe count", 32'(spc.size()), 32'd3);
        for (int i = 0; i < spc.size() && i < 3; i++) chk($sformatf("bp strobe%0d pc", i), 32'(spc[i]), 32'(i));
        chk("bp halt pc", 32'(pc_i), 32'd3);
        chk("bp halt exec", 32'(exec_mode_o), 32'd0);
        tick(); tick();
        chk("bp hold state", 32'(state_o), 32'd4);
        chk("bp hold exec", 32'(exec_mode_o), 32'd0);
        mode_i = 2'b11; tick();
        chk("bp to step state", 32'(state_o), 32'd3);
        step_req_i = 1'b1; tick();
        chk("bp step exec", 32'(exec_mode_o), 32'd1);
        chk("bp step pc", 32'(pc_i), 32'd3);
        step_req_i = 1'b0;
`else
        nstrobe = 0; brk_seen = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (exec_mode_o) begin
                nstrobe++;
                pc_i = pc_i + 4'd1;
            end
            if (state_o == 3'd4) brk_seen++;
        end
        chk("nobp strobe count", 32'(nstrobe), 32'd4);
        chk("nobp final pc", 32'(pc_i), 32'd4);
        chk("nobp brk seen", 32'(brk_seen), 32'd0);
        chk("nobp state", 32'(state_o), 32'd2);
`endif
        bp_en_i = 1'b0;

        // Randomized traffic against the reference model
        mode_i = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = (cyc == 0) ? 1'b0 : ($urandom_range(63) != 0);
            if ($urandom_range(31) == 0) mode_i = 2'($urandom_range(3));
            load_valid_i = 1'($urandom_range(1));
            load_data_i = 8'($urandom);
            step_req_i = ($urandom_range(2) == 0);
            pc_i = 4'($urandom);
            bp_en_i = 1'($urandom_range(1));
            if ($urandom_range(31) == 0) bp_addr_i = 4'($urandom);
            model_edge();
            tick();
            chk("rand state", 32'(state_o), 32'(m_state));
            chk("rand exec", 32'(exec_mode_o), 32'(m_exec));
            chk("rand ready", 32'(load_ready_o), 32'(m_state == 1 && m_n < 16));
            chk("rand full", 32'(prog_full_o), 32'(m_n == 16));
            chk("rand addr", 32'(load_addr_o), 32'(m_n % 16));
            chk("rand word", 32'({opcode_o, immediate_o}), 32'(m_mem[pc_i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
